// File: rtl/pwm_generator_pkg.sv
// rtl/pwm_generator_pkg.sv - shared constants and clamp helper for the PWM generator
package pwm_generator_pkg;

    localparam logic [15:0] MIN_PWM_TIME_HIGH_US = 16'd1000;
    localparam logic [15:0] MAX_PWM_TIME_HIGH_US = 16'd2000;
    localparam logic [15:0] ALL_ZERO_2BYTE       = 16'd0;
    localparam logic [15:0] ONE                  = 16'd1;
    localparam logic        HIGH                 = 1'b1;
    localparam logic        LOW                  = 1'b0;

    // Limit a commanded pulse to the range an ESC/servo accepts (unsigned compare).
    function automatic logic [15:0] clamp_pulse(input logic [15:0] value);
        if (value < MIN_PWM_TIME_HIGH_US) begin
            return MIN_PWM_TIME_HIGH_US;
        end else if (value > MAX_PWM_TIME_HIGH_US) begin
            return MAX_PWM_TIME_HIGH_US;
        end
        return value;
    endfunction

endpackage

// File: rtl/pwm_generator_if.sv
// rtl/pwm_generator_if.sv - command/status bundle between the command source and the PWM generator
interface pwm_generator_if;

    logic [15:0] pulse_len_us;
    logic        pulse_len_valid;
    logic        enable;
    logic        pwm;
    logic [15:0] active_len_us;
    logic        period_start;
    logic        failsafe;

    // The command source drives the pulse command and enable, and watches the PWM status.
    modport master (
        output pulse_len_us, pulse_len_valid, enable,
        input  pwm, active_len_us, period_start, failsafe
    );

    // The generator consumes the command and produces the PWM status.
    modport slave (
        input  pulse_len_us, pulse_len_valid, enable,
        output pwm, active_len_us, period_start, failsafe
    );

endinterface

// File: rtl/pwm_generator_cmd_shadow.sv
// rtl/pwm_generator_cmd_shadow.sv - clamped command shadow register and stale-command watchdog
module pwm_cmd_shadow
    import pwm_generator_pkg::*;
#(
    parameter logic [15:0] DEFAULT_PWM_TIME_HIGH_US = 16'd1000,
    parameter logic [7:0]  TIMEOUT_PERIODS          = 8'd50
) (
    input  logic        us_clk,
    input  logic        resetn,
    input  logic [15:0] i_pulse_len_us,
    input  logic        i_pulse_len_valid,
    input  logic        i_load_tick,
    output logic [15:0] o_shadow_us,
    output logic        o_failsafe
);

    logic [15:0] r_shadow_us;
    logic [7:0]  r_stale_cnt;
    logic        r_failsafe;

    // A fresh command refreshes the shadow and clears the watchdog; each period load without one ages it.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            r_shadow_us <= DEFAULT_PWM_TIME_HIGH_US;
            r_stale_cnt <= 8'd0;
            r_failsafe  <= LOW;
        end else if (i_pulse_len_valid) begin
            r_shadow_us <= clamp_pulse(i_pulse_len_us);
            r_stale_cnt <= 8'd0;
            r_failsafe  <= LOW;
        end else if (i_load_tick && (r_stale_cnt != TIMEOUT_PERIODS)) begin
            r_stale_cnt <= r_stale_cnt + 8'd1;
            r_failsafe  <= ((r_stale_cnt + 8'd1) == TIMEOUT_PERIODS);
        end
    end

    assign o_shadow_us = r_shadow_us;
    assign o_failsafe  = r_failsafe;

endmodule

// File: rtl/pwm_generator.sv
// rtl/pwm_generator.sv - fixed-period PWM output with period-boundary command updates and failsafe
module pwm_generator
    import pwm_generator_pkg::*;
#(
    parameter logic [15:0] PERIOD_US                = 16'd2500,
    parameter logic [15:0] DEFAULT_PWM_TIME_HIGH_US = 16'd1000,
    parameter logic [7:0]  TIMEOUT_PERIODS          = 8'd50
) (
    input  logic           us_clk,
    input  logic           resetn,
    pwm_generator_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } pwm_state_e;

    // The low phase must leave room for at least one low cycle plus the load cycle.
    if (PERIOD_US < (MAX_PWM_TIME_HIGH_US + 16'd2)) begin : g_period_check
        $error("PERIOD_US must be at least MAX_PWM_TIME_HIGH_US + 2");
    end

    pwm_state_e  r_state;
    logic [15:0] r_period_cnt;
    logic [15:0] r_active_len_us;
    logic        r_pwm;
    logic        r_period_start;
    logic [15:0] w_shadow_us;
    logic        w_failsafe;
    logic        w_load_tick;

    assign w_load_tick = (r_state == S_LOAD);

    pwm_cmd_shadow #(
        .DEFAULT_PWM_TIME_HIGH_US (DEFAULT_PWM_TIME_HIGH_US),
        .TIMEOUT_PERIODS          (TIMEOUT_PERIODS)
    ) u_cmd_shadow (
        .us_clk            (us_clk),
        .resetn            (resetn),
        .i_pulse_len_us    (bus.pulse_len_us),
        .i_pulse_len_valid (bus.pulse_len_valid),
        .i_load_tick       (w_load_tick),
        .o_shadow_us       (w_shadow_us),
        .o_failsafe        (w_failsafe)
    );

    // Period sequencer: load the next high time, drive high, then low until the period boundary.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            r_state         <= S_IDLE;
            r_period_cnt    <= ALL_ZERO_2BYTE;
            r_active_len_us <= DEFAULT_PWM_TIME_HIGH_US;
            r_pwm           <= LOW;
            r_period_start  <= LOW;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_pwm          <= LOW;
                    r_period_start <= LOW;
                    r_period_cnt   <= ALL_ZERO_2BYTE;
                    if (bus.enable) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_active_len_us <= w_failsafe ? DEFAULT_PWM_TIME_HIGH_US : w_shadow_us;
                    r_period_cnt    <= ALL_ZERO_2BYTE;
                    r_pwm           <= HIGH;
                    r_period_start  <= HIGH;
                    r_state         <= S_HIGH;
                end
                S_HIGH: begin
                    r_period_start <= LOW;
                    r_period_cnt   <= r_period_cnt + ONE;
                    if (r_period_cnt == (r_active_len_us - ONE)) begin
                        r_pwm   <= LOW;
                        r_state <= S_LOW;
                    end
                end
                S_LOW: begin
                    r_period_cnt <= r_period_cnt + ONE;
                    if (r_period_cnt == (PERIOD_US - 16'd2)) begin
                        r_state <= bus.enable ? S_LOAD : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_pwm   <= LOW;
                end
            endcase
        end
    end

    assign bus.pwm           = r_pwm;
    assign bus.active_len_us = r_active_len_us;
    assign bus.period_start  = r_period_start;
    assign bus.failsafe      = w_failsafe;

endmodule

// File: tb/tb_pwm_generator.sv
// tb/tb_pwm_generator.sv - self-checking bench for pwm_generator
module tb_pwm_generator;

    localparam int P   = 2500;
    localparam int DEF = 1000;
    localparam int TO  = 6;
    localparam int BOUND = 6000;

    logic us_clk = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    pwm_generator_if bus();

    pwm_generator #(
        .PERIOD_US                (16'd2500),
        .DEFAULT_PWM_TIME_HIGH_US (16'd1000),
        .TIMEOUT_PERIODS          (8'd6)
    ) dut (
        .us_clk (us_clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 us_clk = ~us_clk;

    always @(posedge us_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: position within the period, where slot P-1 is the load slot.
    bit m_idle;
    int m_pos;
    int m_len;
    int m_shadow;
    int m_stale;

    function automatic int clampv(input int v);
        if (v < 1000) return 1000;
        if (v > 2000) return 2000;
        return v;
    endfunction

    always @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            m_idle   <= 1'b1;
            m_pos    <= 0;
            m_len    <= DEF;
            m_shadow <= DEF;
            m_stale  <= 0;
        end else begin
            if (m_idle) begin
                if (bus.enable) begin
                    m_idle <= 1'b0;
                    m_pos  <= P - 1;
                end
            end else if (m_pos == P - 1) begin
                m_len <= (m_stale == TO) ? DEF : m_shadow;
                m_pos <= 0;
                if (m_stale < TO) m_stale <= m_stale + 1;
            end else if (m_pos == P - 2) begin
                if (bus.enable) m_pos <= P - 1;
                else            m_idle <= 1'b1;
            end else begin
                m_pos <= m_pos + 1;
            end
            if (bus.pulse_len_valid) begin
                m_shadow <= clampv(int'(bus.pulse_len_us));
                m_stale  <= 0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge us_clk) begin
        check("pwm", {31'd0, bus.pwm}, {31'd0, (!m_idle && m_pos < m_len)});
        check("period_start", {31'd0, bus.period_start}, {31'd0, (!m_idle && m_pos == 0)});
        check("active_len_us", {16'd0, bus.active_len_us}, m_len);
        check("failsafe", {31'd0, bus.failsafe}, {31'd0, (m_stale == TO)});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge us_clk);
    endtask

    task automatic strobe(input int v);
        bus.pulse_len_us    = 16'(v);
        bus.pulse_len_valid = 1'b1;
        @(negedge us_clk);
        bus.pulse_len_valid = 1'b0;
    endtask

    // Returns the cycle of the first high sample of the next pulse.
    task automatic wait_rise(input string name, output int rc);
        int n;
        n = 0;
        while (bus.pwm === 1'b1 && n < BOUND) begin
            @(negedge us_clk);
            n++;
        end
        n = 0;
        while (bus.pwm !== 1'b1 && n < BOUND) begin
            @(negedge us_clk);
            n++;
        end
        if (n >= BOUND) check({name, "_rise_timeout"}, 32'd0, 32'd1);
        rc = cyc;
    endtask

    // Counts high samples from the current one onward.
    task automatic count_high(output int len);
        len = 0;
        while (bus.pwm === 1'b1 && len < BOUND) begin
            len++;
            @(negedge us_clk);
        end
    endtask

    task automatic measure(input string name, output int len, output int rc);
        wait_rise(name, rc);
        count_high(len);
    endtask

    int en_cyc, len, r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, rr, highs;

    initial begin
        bus.pulse_len_us    = 16'd0;
        bus.pulse_len_valid = 1'b0;
        bus.enable          = 1'b0;

        // Reset state
        tick(3);
        check("rst_pwm", {31'd0, bus.pwm}, 32'd0);
        check("rst_active_len", {16'd0, bus.active_len_us}, 32'd1000);
        check("rst_failsafe", {31'd0, bus.failsafe}, 32'd0);
        check("rst_period_start", {31'd0, bus.period_start}, 32'd0);
        #2 resetn = 1'b1;
        tick(3);
        check("idle_pwm", {31'd0, bus.pwm}, 32'd0);

        // Default pulses, no command
        en_cyc = cyc;
        bus.enable = 1'b1;
        measure("s1a", len, r0);
        check("first_rise_latency", r0 - en_cyc, 32'd2);
        check("s1_len0", len, 32'd1000);
        measure("s1b", len, r1);
        check("s1_len1", len, 32'd1000);
        check("s1_spacing1", r1 - r0, 32'd2500);
        measure("s1c", len, r2);
        check("s1_len2", len, 32'd1000);
        check("s1_spacing2", r2 - r1, 32'd2500);
        check("s1_failsafe", {31'd0, bus.failsafe}, 32'd0);

        // Command 1500 mid-high: current period untouched
        wait_rise("s2", r3);
        tick(100);
        strobe(1500);
        count_high(len);
        check("s2_cur_len", 101 + len, 32'd1000);
        check("s2_spacing", r3 - r2, 32'd2500);
        measure("s2n", len, r4);
        check("s2_next_len", len, 32'd1500);
        check("s2_active_len", {16'd0, bus.active_len_us}, 32'd1500);

        // Clamp low, clamp high, strobe coinciding with load
        wait_rise("s3", r5);
        tick(10);
        strobe(800);
        count_high(len);
        check("s3_cur_len", 11 + len, 32'd1500);
        measure("s3a", len, r6);
        check("s3_clamp_min", len, 32'd1000);
        strobe(2600);
        measure("s3b", len, r7);
        check("s3_clamp_max", len, 32'd2000);
        rr = 0;
        while (cyc < r7 + 2499 && rr < BOUND) begin
            @(negedge us_clk);
            rr++;
        end
        strobe(1300);
        check("s3_load_rise", {31'd0, bus.pwm}, 32'd1);
        check("s3_load_rise_cycle", cyc - r7, 32'd2500);
        count_high(len);
        check("s3_load_keeps_old", len, 32'd2000);
        measure("s3c", len, r8);
        check("s3_after_load", len, 32'd1300);

        // Watchdog
        wait_rise("s4", r9);
        tick(5);
        strobe(1700);
        count_high(len);
        check("s4_cur_len", 6 + len, 32'd1300);
        for (int i = 1; i <= TO; i++) begin
            if (i == TO) check("s4_failsafe_before", {31'd0, bus.failsafe}, 32'd0);
            measure("s4p", len, rr);
            check("s4_stale_len", len, 32'd1700);
        end
        check("s4_failsafe_set", {31'd0, bus.failsafe}, 32'd1);
        measure("s4f", len, rr);
        check("s4_failsafe_len", len, 32'd1000);
        strobe(1200);
        check("s4_failsafe_clear", {31'd0, bus.failsafe}, 32'd0);
        measure("s4r", len, rr);
        check("s4_recover_len", len, 32'd1200);

        // Enable dropped mid-pulse
        strobe(1500);
        wait_rise("s5", r10);
        tick(299);
        bus.enable = 1'b0;
        count_high(len);
        check("s5_full_high", 299 + len, 32'd1500);
        highs = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge us_clk);
            if (bus.pwm !== 1'b0) highs++;
        end
        check("s5_stays_low", highs, 32'd0);
        en_cyc = cyc;
        bus.enable = 1'b1;
        measure("s5r", len, rr);
        check("s5_reenable_latency", rr - en_cyc, 32'd2);
        check("s5_reenable_len", len, 32'd1500);

        // Asynchronous reset mid-high
        wait_rise("s6", rr);
        tick(50);
        #2 resetn = 1'b0;
        #1;
        check("s6_async_pwm", {31'd0, bus.pwm}, 32'd0);
        check("s6_async_active", {16'd0, bus.active_len_us}, 32'd1000);
        check("s6_async_failsafe", {31'd0, bus.failsafe}, 32'd0);
        bus.enable = 1'b0;
        tick(3);
        #2 resetn = 1'b1;
        tick(10);
        check("s6_idle_after_reset", {31'd0, bus.pwm}, 32'd0);
        en_cyc = cyc;
        bus.enable = 1'b1;
        measure("s6r", len, rr);
        check("s6_rise_latency", rr - en_cyc, 32'd2);
        check("s6_default_len", len, 32'd1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
